// File: rtl/uart_pkg.sv
// Shared definitions for the word-oriented UART transmit and receive engines:
// sequencer state encoding, frame geometry and the frame length helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int DATA_BITS      = 8;

   // Bits per frame: start + data + optional parity + stop bits.
   function automatic int frame_bits(input int parity_en, input int stop_bits);
      return 1 + DATA_BITS + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO with first-word-fall-through read data.
// A push is refused whenever the FIFO is full, even if a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == FULL_LVL);
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: occupancy is tracked solely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_word_tx.sv
// UART transmit engine: serialises queued 32-bit words as four byte frames, byte 0 first,
// with back-to-back frames and words whenever data is waiting.
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 10416,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [31:0]                   s_data,
   output logic                          uart_tx,
   output logic                          busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int             CW        = $clog2(CLK_DIV);
   localparam logic [CW-1:0]  CNT_MAX   = CW'(CLK_DIV - 1);
   localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [1:0]     BYTE_LAST = 2'(BYTES_PER_WORD - 1);
   localparam logic           PAR_ODD   = (PARITY_ODD != 0);

   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_word_tx: STOP_BITS must be 1 or 2");
   end

   tx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [1:0]    byte_next;
   logic [31:0]   word_q, word_d;
   logic [7:0]    byte_q, byte_d;
   logic          busy_q;
   logic          bit_end;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [31:0]   fifo_rdata;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (s_valid),
      .wdata_i (s_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign s_ready = !fifo_full;
   assign busy    = busy_q;
   assign bit_end = (cnt_q == CNT_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         byte_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         byte_q     <= byte_d;
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      byte_d     = byte_q;
      fifo_pop   = 1'b0;
      tx_done    = 1'b0;
      uart_tx    = 1'b1;
      byte_next  = byte_idx_q + 2'd1;

      if (state_q != ST_IDLE && state_q != ST_LOAD && !bit_end)
         cnt_d = cnt_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               word_d     = fifo_rdata;
               byte_idx_d = '0;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            byte_d  = word_q[{byte_idx_q, 3'b000} +: 8];
            state_d = ST_START;
         end
         ST_START: begin
            uart_tx = 1'b0;
            if (bit_end) begin
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            uart_tx = byte_q[bit_idx_q];
            if (bit_end) begin
               if (bit_idx_q == DATA_LAST) begin
                  bit_idx_d = '0;
                  state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            uart_tx = (^byte_q) ^ PAR_ODD;
            if (bit_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            // The next byte or word is latched in the last stop cycle so frames abut.
            if (bit_end) begin
               if (bit_idx_q != STOP_LAST) begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end else begin
                  bit_idx_d = '0;
                  if (byte_idx_q != BYTE_LAST) begin
                     byte_idx_d = byte_next;
                     byte_d     = word_q[{byte_next, 3'b000} +: 8];
                     state_d    = ST_START;
                  end else begin
                     tx_done = 1'b1;
                     if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        word_d     = fifo_rdata;
                        byte_d     = fifo_rdata[7:0];
                        byte_idx_d = '0;
                        state_d    = ST_START;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: four configurations (default, even parity, odd parity, two stop bits),
// line waveform compared cycle by cycle against a bit-list model of each frame.
module tb_uart_word_tx;

   localparam int         NI     = 4;
   localparam int         DIV    = 4;
   localparam logic [3:0] PE_V   = 4'b0110;
   localparam logic [3:0] ODD_V  = 4'b0100;
   localparam logic [3:0] SB2_V  = 4'b1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid    [NI];
   logic [31:0] s_data     [NI];
   logic        s_ready    [NI];
   logic        uart_tx    [NI];
   logic        busy       [NI];
   logic        tx_done    [NI];
   logic [2:0]  fifo_level [NI];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      uart_word_tx #(
         .CLK_DIV    (DIV),
         .FIFO_DEPTH (4),
         .PARITY_EN  (int'(PE_V[gi])),
         .PARITY_ODD (int'(ODD_V[gi])),
         .STOP_BITS  (SB2_V[gi] ? 2 : 1)
      ) u_dut (
         .clk        (clk),
         .reset      (rst_n),
         .s_valid    (s_valid[gi]),
         .s_ready    (s_ready[gi]),
         .s_data     (s_data[gi]),
         .uart_tx    (uart_tx[gi]),
         .busy       (busy[gi]),
         .tx_done    (tx_done[gi]),
         .fifo_level (fifo_level[gi])
      );
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   logic [0:0] exp_q[$];

   function automatic int frame_len(input int i);
      return 1 + 8 + int'(PE_V[i]) + (SB2_V[i] ? 2 : 1);
   endfunction

   task automatic build_model(input int i, input logic [31:0] words[$]);
      exp_q.delete();
      foreach (words[w]) begin
         for (int b = 0; b < 4; b++) begin
            logic [7:0] by;
            logic [0:0] bits[$];
            by = 8'(words[w] >> (8 * b));
            bits.delete();
            bits.push_back(1'b0);
            for (int k = 0; k < 8; k++) bits.push_back(by[k]);
            if (PE_V[i]) bits.push_back(1'(($countones(by) % 2) ^ int'(ODD_V[i])));
            repeat (SB2_V[i] ? 2 : 1) bits.push_back(1'b1);
            foreach (bits[j]) repeat (DIV) exp_q.push_back(bits[j]);
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic push_word(input int i, input logic [31:0] w, output int acc);
      logic rdy;
      s_valid[i] = 1'b1;
      s_data[i]  = w;
      acc = -1;
      for (int t = 0; t < 600; t++) begin
         rdy = s_ready[i];
         @(posedge clk);
         #1;
         if (rdy) begin
            acc = cyc;
            break;
         end
      end
      check("push_accepted", acc >= 0, 1);
   endtask

   // ---------------- line capture ----------------
   logic cap_line[$];
   int   cap_done[$];
   int   cap_busy_low;
   int   cap_start;
   logic [2:0] cap_after;

   task automatic capture(input int i, input int n);
      cap_line.delete();
      cap_done.delete();
      cap_busy_low = 0;
      cap_start    = -1;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (uart_tx[i] === 1'b0) begin
            cap_start = cyc;
            break;
         end
      end
      check("start_seen", cap_start >= 0, 1);
      if (cap_start < 0) return;
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk);
         cap_line.push_back(uart_tx[i]);
         if (tx_done[i] === 1'b1) cap_done.push_back(k);
         if (busy[i] !== 1'b1) cap_busy_low++;
      end
      @(negedge clk);
      cap_after = {busy[i], uart_tx[i], tx_done[i]};
   endtask

   task automatic verify(input int i, input logic [31:0] words[$], input string tag);
      int errs;
      int derr;
      int len;
      build_model(i, words);
      len  = 4 * frame_len(i) * DIV;
      errs = 0;
      foreach (exp_q[k]) if (k >= cap_line.size() || cap_line[k] !== exp_q[k]) errs++;
      check({tag, "_line"}, errs, 0);
      check({tag, "_done_count"}, cap_done.size(), words.size());
      derr = 0;
      foreach (cap_done[d]) if (cap_done[d] != (d + 1) * len - 1) derr++;
      check({tag, "_done_pos"}, derr, 0);
      check({tag, "_busy_in_frame"}, cap_busy_low, 0);
      check({tag, "_after_busy_line_done"}, cap_after, 3'b010);
   endtask

   // ---------------- test table ----------------
   typedef struct {
      int          inst;
      logic [31:0] word;
      int          cycles;
      logic [3:0]  par;
   } vec_t;

   vec_t        vecs[5];
   logic [31:0] wq[$];
   int          acc[6];
   int          a0;

   initial begin
      vecs[0] = '{0, 32'hA5C30F81, 160, 4'b0000};
      vecs[1] = '{1, 32'h00000007, 176, 4'b0001};
      vecs[2] = '{2, 32'h00000007, 176, 4'b1110};
      vecs[3] = '{3, 32'hA5C30F81, 176, 4'b0000};
      vecs[4] = '{1, 32'hFF8001FE, 176, 4'b0111};

      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         s_valid[i] = 1'b0;
         s_data[i]  = '0;
      end
      #1;
      check("reset_outputs", {uart_tx[0], s_ready[0], busy[0], tx_done[0], fifo_level[0]}, 7'b1100000);
      check("reset_line_stop2", uart_tx[3], 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {uart_tx[0], s_ready[0], busy[0]}, 3'b110);

      // Single words across configurations.
      foreach (vecs[v]) begin
         logic [31:0] dec;
         logic [3:0]  par;
         int          f;
         int          hi;
         @(negedge clk);
         fork
            begin
               push_word(vecs[v].inst, vecs[v].word, a0);
               s_valid[vecs[v].inst] = 1'b0;
            end
            capture(vecs[v].inst, vecs[v].cycles);
         join
         f = frame_len(vecs[v].inst);
         check($sformatf("v%0d_latency", v), cap_start - a0, 2);
         check($sformatf("v%0d_word_cycles", v), (cap_done.size() > 0) ? cap_done[0] + 1 : -1, vecs[v].cycles);
         dec = '0;
         par = '0;
         for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) dec[8 * b + k] = cap_line[b * f * DIV + (1 + k) * DIV + DIV / 2];
            if (PE_V[vecs[v].inst]) par[b] = cap_line[b * f * DIV + 9 * DIV + DIV / 2];
         end
         check($sformatf("v%0d_decoded_word", v), dec, vecs[v].word);
         if (PE_V[vecs[v].inst]) check($sformatf("v%0d_parity_bits", v), par, vecs[v].par);
         if (SB2_V[vecs[v].inst]) begin
            hi = 0;
            for (int k = 36; k < 44; k++) hi += int'(cap_line[k]);
            check($sformatf("v%0d_stop_gap", v), {hi[3:0], cap_line[44]}, {4'd8, 1'b0});
         end
         wq.delete();
         wq.push_back(vecs[v].word);
         verify(vecs[v].inst, wq, $sformatf("v%0d", v));
      end

      // Backpressure: five words with s_valid held, then a sixth offer while full.
      wq.delete();
      for (int k = 0; k < 6; k++) wq.push_back($urandom);
      @(negedge clk);
      fork
         begin
            int serr;
            for (int k = 0; k < 5; k++) push_word(0, wq[k], acc[k]);
            check("bp_full_state", {s_ready[0], fifo_level[0]}, {1'b0, 3'd4});
            serr = 0;
            for (int k = 1; k < 5; k++) if (acc[k] - acc[0] != k) serr++;
            check("bp_accept_sequence", serr, 0);
            push_word(0, wq[5], acc[5]);
            s_valid[0] = 1'b0;
            check("bp_sixth_accept", acc[5] - acc[0], 163);
         end
         capture(0, 6 * 160);
      join
      check("bp_latency", cap_start - acc[0], 2);
      verify(0, wq, "bp");

      // Simultaneous push and pop with two words queued.
      wq.delete();
      for (int k = 0; k < 4; k++) wq.push_back($urandom);
      @(negedge clk);
      fork
         begin
            for (int k = 0; k < 3; k++) push_word(0, wq[k], acc[k]);
            s_valid[0] = 1'b0;
            check("pp_level_before", fifo_level[0], 3'd2);
            while (cyc < acc[0] + 161) begin
               @(posedge clk);
               #1;
            end
            push_word(0, wq[3], acc[3]);
            s_valid[0] = 1'b0;
            check("pp_accept_on_pop", acc[3] - acc[0], 162);
            check("pp_level_after", fifo_level[0], 3'd2);
         end
         capture(0, 4 * 160);
      join
      verify(0, wq, "pp");

      // Asynchronous reset in byte 2, data bit 3 with two words queued.
      wq.delete();
      for (int k = 0; k < 3; k++) wq.push_back($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) push_word(0, wq[k], acc[k]);
      s_valid[0] = 1'b0;
      check("rst_queued", fifo_level[0], 3'd2);
      do @(negedge clk); while (cyc < acc[0] + 99);
      check("rst_pre_bit", uart_tx[0], wq[0][19]);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_outputs", {uart_tx[0], s_ready[0], busy[0], tx_done[0], fifo_level[0]}, 7'b1100000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wq.delete();
      wq.push_back(32'h12345678);
      fork
         begin
            push_word(0, 32'h12345678, a0);
            s_valid[0] = 1'b0;
         end
         capture(0, 160);
      join
      check("rst_new_latency", cap_start - a0, 2);
      verify(0, wq, "rst");
      begin
         int ierr;
         ierr = 0;
         for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (uart_tx[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_level[0] !== 3'd0) ierr++;
         end
         check("rst_no_old_words", ierr, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
